cache_line_ctrl: RTL and testbench

CACHE_LINE_CTRL -- requirements
Module: cache_line_ctrl

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_line_ctrl_if.sv | 31 +++
 rtl/onehot_decoder.sv | 12 +
 rtl/cache_line_ctrl.sv | 118 +++++++++++
 tb/tb_cache_line_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared encodings for the cache line controller: request opcodes
// and controller states.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_FILL   = 2'b01,
        OP_INVAL  = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/cache_line_ctrl_if.sv
// Request/response bundle between a requester and the cache line
// controller, including the per-line select and valid vectors.
interface cache_line_ctrl_if
    import cache_pkg::*;
#(
    parameter int INDEX_W = 7
) ();
    localparam int LINES = 2 ** INDEX_W;

    logic               req_valid;
    logic               req_ready;
    op_e                req_op;
    logic [INDEX_W-1:0] req_index;
    logic [LINES-1:0]   line_en;
    logic               line_we;
    logic               rsp_valid;
    logic               rsp_hit;
    logic [LINES-1:0]   valid_vec;

    modport master (
        output req_valid, req_op, req_index,
        input  req_ready, line_en, line_we,
        input  rsp_valid, rsp_hit, valid_vec
    );

    modport slave (
        input  req_valid, req_op, req_index,
        output req_ready, line_en, line_we,
        output rsp_valid, rsp_hit, valid_vec
    );
endinterface

// File: rtl/onehot_decoder.sv
// Combinational index to one-hot line select.
module onehot_decoder #(
    parameter int INDEX_W = 7
) (
    input  logic [INDEX_W-1:0]    index,
    output logic [2**INDEX_W-1:0] onehot
);
    always_comb begin
        onehot        = '0;
        onehot[index] = 1'b1;
    end
endmodule

// File: rtl/cache_line_ctrl.sv
// Per-line valid tracking with single-line requests and a
// sequential flush sweep that shares the line-select decoder.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W = 7
) (
    input logic              clk,
    input logic              rst_n,
    cache_line_ctrl_if.slave bus
);
    localparam int LINES = 2 ** INDEX_W;

    state_e             state, state_nx;
    logic [INDEX_W-1:0] cnt, cnt_nx;
    logic [INDEX_W-1:0] dec_index;
    logic [LINES-1:0]   dec_onehot;
    logic [LINES-1:0]   vv, vv_nx;
    logic [LINES-1:0]   en, en_nx;
    logic               we, we_nx;
    logic               rv, rv_nx;
    logic               hit, hit_nx;
    logic               accept;

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && (state == ST_IDLE);

    // The select register always shows the line being touched this cycle,
    // so the sweep decodes one ahead of the counter.
    always_comb begin
        dec_index = bus.req_index;
        if (state == ST_FLUSH)
            dec_index = cnt + 1'b1;
        else if (bus.req_op == OP_FLUSH)
            dec_index = '0;
    end

    onehot_decoder #(.INDEX_W(INDEX_W)) u_dec (
        .index  (dec_index),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        vv_nx    = vv;
        en_nx    = '0;
        we_nx    = 1'b0;
        rv_nx    = 1'b0;
        hit_nx   = 1'b0;
        unique case (1'b1)
            (state == ST_FLUSH): begin
                vv_nx[cnt] = 1'b0;
                if (cnt == INDEX_W'(LINES - 1)) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    rv_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    en_nx  = dec_onehot;
                end
            end
            accept: begin
                unique case (bus.req_op)
                    OP_LOOKUP: begin
                        rv_nx  = 1'b1;
                        en_nx  = dec_onehot;
                        hit_nx = vv[bus.req_index];
                    end
                    OP_FILL: begin
                        rv_nx = 1'b1;
                        en_nx = dec_onehot;
                        we_nx = 1'b1;
                        vv_nx[bus.req_index] = 1'b1;
                    end
                    OP_INVAL: begin
                        rv_nx = 1'b1;
                        en_nx = dec_onehot;
                        vv_nx[bus.req_index] = 1'b0;
                    end
                    OP_FLUSH: begin
                        state_nx = ST_FLUSH;
                        cnt_nx   = '0;
                        en_nx    = dec_onehot;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            vv    <= '0;
            en    <= '0;
            we    <= 1'b0;
            rv    <= 1'b0;
            hit   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            vv    <= vv_nx;
            en    <= en_nx;
            we    <= we_nx;
            rv    <= rv_nx;
            hit   <= hit_nx;
        end
    end

    assign bus.line_en   = en;
    assign bus.line_we   = we;
    assign bus.rsp_valid = rv;
    assign bus.rsp_hit   = hit;
    assign bus.valid_vec = vv;
endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: 128-line and 8-line instances checked
// every cycle against a behavioural model, plus literal scenarios.
module tb_cache_line_ctrl;
    import cache_pkg::*;

    localparam int HN = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst7_n, rst3_n;

    cache_line_ctrl_if #(.INDEX_W(7)) b7 ();
    cache_line_ctrl_if #(.INDEX_W(3)) b3 ();

    cache_line_ctrl #(.INDEX_W(7)) u7 (
        .clk   (clk),
        .rst_n (rst7_n),
        .bus   (b7.slave)
    );

    cache_line_ctrl #(.INDEX_W(3)) u3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (b3.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lines(input int m);
        return (m == 0) ? 128 : 8;
    endfunction

    // Behavioural model: valid bits per line, sweep position (-1 idle),
    // and what each output must show during the current cycle.
    bit mv   [2][128];
    int sp   [2] = '{-1, -1};
    int m_en [2] = '{-1, -1};
    bit m_we [2];
    bit m_rv [2];
    bit m_hit[2];

    task automatic model_reset(input int m);
        for (int i = 0; i < 128; i++) mv[m][i] = 1'b0;
        sp[m]    = -1;
        m_en[m]  = -1;
        m_we[m]  = 1'b0;
        m_rv[m]  = 1'b0;
        m_hit[m] = 1'b0;
    endtask

    task automatic model_step(input int m, input bit v, input int op,
                              input int idx);
        m_en[m]  = -1;
        m_we[m]  = 1'b0;
        m_rv[m]  = 1'b0;
        m_hit[m] = 1'b0;
        if (sp[m] >= 0) begin
            mv[m][sp[m]] = 1'b0;
            if (sp[m] == lines(m) - 1) begin
                sp[m]   = -1;
                m_rv[m] = 1'b1;
            end else begin
                sp[m]   = sp[m] + 1;
                m_en[m] = sp[m];
            end
        end else if (v) begin
            case (op)
                0: begin
                    m_rv[m]  = 1'b1;
                    m_en[m]  = idx;
                    m_hit[m] = mv[m][idx];
                end
                1: begin
                    m_rv[m] = 1'b1;
                    m_en[m] = idx;
                    m_we[m] = 1'b1;
                    mv[m][idx] = 1'b1;
                end
                2: begin
                    m_rv[m] = 1'b1;
                    m_en[m] = idx;
                    mv[m][idx] = 1'b0;
                end
                default: begin
                    sp[m]   = 0;
                    m_en[m] = 0;
                end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst7_n)
        if (!rst7_n) model_reset(0);
        else model_step(0, b7.req_valid, int'(b7.req_op), int'(b7.req_index));

    always @(posedge clk or negedge rst3_n)
        if (!rst3_n) model_reset(1);
        else model_step(1, b3.req_valid, int'(b3.req_op), int'(b3.req_index));

    logic [127:0] h_en [2][HN];
    logic [127:0] h_vv [2][HN];
    bit           h_rv [2][HN];
    bit           h_hit[2][HN];
    bit           h_we [2][HN];
    bit           h_rdy[2][HN];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [127:0] een, evv, aen, avv;
            logic [3:0]   ectl, actl;
            een = '0;
            if (m_en[m] >= 0) een[m_en[m]] = 1'b1;
            evv = '0;
            for (int i = 0; i < lines(m); i++) evv[i] = mv[m][i];
            ectl = {sp[m] < 0, m_rv[m], m_hit[m], m_we[m]};
            if (m == 0) begin
                aen  = b7.line_en;
                avv  = b7.valid_vec;
                actl = {b7.req_ready, b7.rsp_valid, b7.rsp_hit, b7.line_we};
            end else begin
                aen  = 128'(b3.line_en);
                avv  = 128'(b3.valid_vec);
                actl = {b3.req_ready, b3.rsp_valid, b3.rsp_hit, b3.line_we};
            end
            chk(m == 0 ? "ctl7" : "ctl3", 128'(actl), 128'(ectl));
            chk(m == 0 ? "en7" : "en3", aen, een);
            chk(m == 0 ? "vv7" : "vv3", avv, evv);
            if (cyc < HN) begin
                h_en[m][cyc]  = aen;
                h_vv[m][cyc]  = avv;
                h_rv[m][cyc]  = actl[2];
                h_hit[m][cyc] = actl[1];
                h_we[m][cyc]  = actl[0];
                h_rdy[m][cyc] = actl[3];
            end
        end
    end

    // Holds the request until accepted; returns with acc = response cycle.
    task automatic issue(input int m, input int op, input int idx,
                         output int acc);
        int  budget;
        bit  rdy;
        budget = 0;
        if (m == 0) begin
            b7.req_valid = 1'b1;
            b7.req_op    = op_e'(op);
            b7.req_index = 7'(idx);
        end else begin
            b3.req_valid = 1'b1;
            b3.req_op    = op_e'(op);
            b3.req_index = 3'(idx);
        end
        do begin
            @(negedge clk);
            rdy = (m == 0) ? b7.req_ready : b3.req_ready;
            budget++;
        end while (!rdy && budget < 400);
        if (!rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout m=%0d: ready %0b want 1", m, rdy);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (m == 0) b7.req_valid = 1'b0;
        else b3.req_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_traffic(input int m, input int n, input int pflush);
        int r, op, idx, a;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35) op = 0;
            else if (r < 70) op = 1;
            else if (r < 100 - pflush) op = 2;
            else op = 3;
            if ($urandom_range(0, 3) == 0) idx = $urandom_range(0, lines(m) - 1);
            else idx = $urandom_range(0, (m == 0) ? 15 : 3);
            issue(m, op, idx, a);
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
    endtask

    int a, a1, a2, a3, f, l;
    logic [127:0] one128;

    initial begin
        one128 = 128'd1;
        rst7_n = 1'b0;
        rst3_n = 1'b0;
        b7.req_valid = 1'b0;
        b7.req_op    = OP_LOOKUP;
        b7.req_index = '0;
        b3.req_valid = 1'b0;
        b3.req_op    = OP_LOOKUP;
        b3.req_index = '0;
        #12;
        chk("rst_ready", 128'(b7.req_ready), 128'd1);
        chk("rst_en", b7.line_en, 128'd0);
        chk("rst_ctl", 128'({b7.rsp_valid, b7.rsp_hit, b7.line_we}), 128'd0);
        #10;
        rst7_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 128'(b7.req_ready), 128'd1);

        issue(0, 1, 0, a);
        gap(2);
        chk("fill0_en", h_en[0][a], 128'd1);
        chk("fill0_we_rv", 128'({h_we[0][a], h_rv[0][a]}), 128'd3);
        chk("fill0_vv", h_vv[0][a], 128'd1);

        issue(0, 1, 127, a1);
        issue(0, 0, 127, a2);
        issue(0, 0, 32, a3);
        gap(2);
        chk("b2b_gap", 128'(a3 - a1), 128'd2);
        chk("lk127_hit", 128'({h_rv[0][a2], h_hit[0][a2]}), 128'd3);
        chk("lk127_en", h_en[0][a2], one128 << 127);
        chk("lk32_hit", 128'({h_rv[0][a3], h_hit[0][a3], h_we[0][a3]}), 128'd4);
        chk("lk32_en", h_en[0][a3], one128 << 32);

        issue(0, 1, 5, a1);
        issue(0, 2, 5, a2);
        issue(0, 0, 5, a3);
        gap(2);
        chk("fill5_vv", 128'(h_vv[0][a1][5]), 128'd1);
        chk("inval5_we", 128'({h_rv[0][a2], h_we[0][a2]}), 128'd2);
        chk("lk5_hit", 128'({h_rv[0][a3], h_hit[0][a3]}), 128'd2);
        chk("lk5_vv", 128'(h_vv[0][a3][5]), 128'd0);

        rand_traffic(0, 500, 3);
        gap(2);

        for (int i = 0; i < 8; i++) issue(1, 1, i, a);
        issue(1, 3, 0, f);
        issue(1, 0, 3, l);
        gap(2);
        chk("pre_flush_vv", h_vv[1][f - 1], 128'hff);
        for (int k = 0; k < 8; k++) begin
            chk("sweep_ready", 128'(h_rdy[1][f + k]), 128'd0);
            chk("sweep_en", h_en[1][f + k], one128 << k);
        end
        chk("flush_rsp", 128'({h_rdy[1][f + 8], h_rv[1][f + 8], h_hit[1][f + 8]}),
            128'd6);
        chk("flush_en_done", h_en[1][f + 8], 128'd0);
        chk("flush_vv", h_vv[1][f + 8], 128'd0);
        chk("held_lk_cyc", 128'(l - f), 128'd9);
        chk("held_lk_rsp", 128'({h_rv[1][l], h_hit[1][l], h_en[1][l][3]}), 128'd5);

        issue(1, 1, 1, a);
        issue(1, 1, 6, a);
        issue(1, 3, 0, f);
        while (cyc < f + 3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_en", 128'(b3.line_en), 128'h08);
        #1;
        rst3_n = 1'b0;
        #1;
        chk("midrst_en", 128'(b3.line_en), 128'd0);
        chk("midrst_vv", 128'(b3.valid_vec), 128'd0);
        chk("midrst_ctl", 128'({b3.rsp_valid, b3.rsp_hit, b3.line_we}), 128'd0);
        #1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 128'(b3.req_ready), 128'd1);

        rand_traffic(1, 400, 10);
        gap(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
